axis_frame_len_check: RTL and testbench

AXIS_FRAME_LEN_CHECK -- requirements
Module: axis_frame_len_check

---
 rtl/axis_frame_len_pkg.sv | 21 ++
 rtl/axis_skid_reg.sv | 55 +++++
 rtl/axis_frame_len_check.sv | 177 +++++++++++++++++
 tb/tb_axis_frame_len_check.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_len_pkg.sv
// rtl/axis_frame_len_pkg.sv - state type and tkeep byte counter for axis_frame_len_check
package axis_frame_len_pkg;

   typedef enum logic [1:0] {
      START = 2'd0,
      MID   = 2'd1,
      DROP  = 2'd2
   } state_t;

   localparam int KEEP_MAX = 256;

   function automatic logic [8:0] popcount(input logic [KEEP_MAX-1:0] keep);
      logic [8:0] cnt;
      cnt = '0;
      for (int i = 0; i < KEEP_MAX; i++) begin
         cnt = cnt + {8'd0, keep[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// rtl/axis_skid_reg.sv - two-entry register slice with registered upstream ready
module axis_skid_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_s_data,
   input  logic             i_s_valid,
   output logic             o_s_ready,
   output logic [WIDTH-1:0] o_m_data,
   output logic             o_m_valid,
   input  logic             i_m_ready
);

   logic [WIDTH-1:0] r_m_data;
   logic [WIDTH-1:0] r_skid_data;
   logic             r_m_valid;
   logic             r_skid_valid;
   logic             r_s_ready;
   logic             w_s_fire;
   logic             w_m_load;

   assign w_s_fire = i_s_valid & r_s_ready;
   assign w_m_load = i_m_ready | ~r_m_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_valid    <= 1'b0;
         r_skid_valid <= 1'b0;
         r_s_ready    <= 1'b1;
      end else if (w_m_load) begin
         r_m_valid    <= r_skid_valid | w_s_fire;
         r_skid_valid <= 1'b0;
         r_s_ready    <= 1'b1;
      end else if (w_s_fire) begin
         r_skid_valid <= 1'b1;
         r_s_ready    <= 1'b0;
      end
   end

   // ready is low whenever the skid holds a beat, so skid and input never compete
   always_ff @(posedge clk) begin
      if (w_m_load) begin
         r_m_data <= r_skid_valid ? r_skid_data : i_s_data;
      end
      if (!w_m_load && w_s_fire) begin
         r_skid_data <= i_s_data;
      end
   end

   assign o_s_ready = r_s_ready;
   assign o_m_data  = r_m_data;
   assign o_m_valid = r_m_valid;

endmodule

// File: rtl/axis_frame_len_check.sv
// rtl/axis_frame_len_check.sv - frame byte-length checker marking short/long frames via tuser
// AXIS_FRAME_LEN_CHECK_TRUNC_EN: cut oversize frames at the limit and drop the rest.
module axis_frame_len_check
   import axis_frame_len_pkg::*;
#(
   parameter int                    DATA_WIDTH           = 32,
   parameter int                    KEEP_WIDTH           = DATA_WIDTH / 8,
   parameter int                    USER_WIDTH           = 1,
   parameter int                    LEN_WIDTH            = 16,
   parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   input  logic [LEN_WIDTH-1:0]  min_len,
   input  logic [LEN_WIDTH-1:0]  max_len,
   output logic [LEN_WIDTH-1:0]  status_frame_len,
   output logic                  status_frame_valid,
   output logic                  status_too_short,
   output logic                  status_too_long
);

   localparam int PAY_W = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [LEN_WIDTH-1:0]  r_count;
   logic [LEN_WIDTH-1:0]  r_min;
   logic [LEN_WIDTH-1:0]  r_max;
   logic [LEN_WIDTH-1:0]  r_stat_len;
   logic                  r_stat_valid;
   logic                  r_stat_short;
   logic                  r_stat_long;

   logic                  w_first;
   logic                  w_in_drop;
   logic                  w_trunc;
   logic                  w_skid_ready;
   logic                  w_s_ready;
   logic                  w_accept;
   logic                  w_push;
   logic [KEEP_MAX-1:0]   w_keep_ext;
   logic [8:0]            w_bytes;
   logic [LEN_WIDTH-1:0]  w_base;
   logic [LEN_WIDTH:0]    w_sum;
   logic [LEN_WIDTH-1:0]  w_len;
   logic [LEN_WIDTH-1:0]  w_min;
   logic [LEN_WIDTH-1:0]  w_max;
   logic                  w_short;
   logic                  w_long;
   logic                  w_bad;
   logic                  w_out_last;
   logic [USER_WIDTH-1:0] w_out_user;
   logic [PAY_W-1:0]      w_s_pay;
   logic [PAY_W-1:0]      w_m_pay;
   logic                  w_m_valid;

   // limits and count come straight from the inputs on a frame's first beat
   assign w_first    = (r_state == START);
   assign w_min      = w_first ? min_len : r_min;
   assign w_max      = w_first ? max_len : r_max;
   assign w_base     = w_first ? '0 : r_count;
   assign w_keep_ext = KEEP_MAX'(s_axis_tkeep);
   assign w_bytes    = popcount(w_keep_ext);
   assign w_sum      = {1'b0, w_base} + (LEN_WIDTH + 1)'(w_bytes);
   assign w_len      = w_sum[LEN_WIDTH] ? '1 : w_sum[LEN_WIDTH-1:0];
   assign w_short    = (w_len < w_min);
   assign w_long     = (w_max != '0) && (w_len > w_max);

`ifdef AXIS_FRAME_LEN_CHECK_TRUNC_EN
   assign w_in_drop = (r_state == DROP);
   assign w_trunc   = ~w_in_drop & w_long & ~s_axis_tlast;
   assign w_s_ready = w_skid_ready | w_in_drop;
`else
   assign w_in_drop = 1'b0;
   assign w_trunc   = 1'b0;
   assign w_s_ready = w_skid_ready;
`endif

   assign s_axis_tready = w_s_ready & ~rst;
   assign w_accept      = s_axis_tvalid & s_axis_tready;
   assign w_push        = s_axis_tvalid & ~w_in_drop & ~rst;

   assign w_bad      = (s_axis_tlast & (w_short | w_long)) | w_trunc;
   assign w_out_last = s_axis_tlast | w_trunc;
   assign w_out_user = s_axis_tuser | (w_bad ? USER_BAD_FRAME_VALUE : '0);
   assign w_s_pay    = {s_axis_tdata, s_axis_tkeep, w_out_last, w_out_user};

   axis_skid_reg #(
      .WIDTH (PAY_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .i_s_data  (w_s_pay),
      .i_s_valid (w_push),
      .o_s_ready (w_skid_ready),
      .o_m_data  (w_m_pay),
      .o_m_valid (w_m_valid),
      .i_m_ready (m_axis_tready)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = w_m_pay;
   assign m_axis_tvalid = w_m_valid & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= START;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         case (r_state)
            START, MID: begin
               w_state_nxt = s_axis_tlast ? START : MID;
`ifdef AXIS_FRAME_LEN_CHECK_TRUNC_EN
               if (w_trunc) begin
                  w_state_nxt = DROP;
               end
            end
            DROP: begin
               if (s_axis_tlast) begin
                  w_state_nxt = START;
               end
`endif
            end
            default: w_state_nxt = START;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count      <= '0;
         r_min        <= '0;
         r_max        <= '0;
         r_stat_valid <= 1'b0;
         r_stat_len   <= '0;
         r_stat_short <= 1'b0;
         r_stat_long  <= 1'b0;
      end else begin
         r_stat_valid <= w_accept & s_axis_tlast;
         if (w_accept) begin
            r_count <= w_len;
            if (w_first) begin
               r_min <= min_len;
               r_max <= max_len;
            end
            if (s_axis_tlast) begin
               r_stat_len   <= w_len;
               r_stat_short <= w_short;
               r_stat_long  <= w_long | w_in_drop;
            end
         end
      end
   end

   assign status_frame_valid = r_stat_valid & ~rst;
   assign status_frame_len   = rst ? '0 : r_stat_len;
   assign status_too_short   = r_stat_short & ~rst;
   assign status_too_long    = r_stat_long & ~rst;

endmodule

// File: tb/tb_axis_frame_len_check.sv
// tb/tb_axis_frame_len_check.sv - directed frame table plus skid/reset sequences for axis_frame_len_check
module tb_axis_frame_len_check;

   localparam int DW = 32;
   localparam int KW = 4;
   localparam int UW = 1;
   localparam int LW = 8;
   localparam int NREC = 19;

`ifdef AXIS_FRAME_LEN_CHECK_TRUNC_EN
   localparam bit TRUNC = 1'b1;
`else
   localparam bit TRUNC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [UW-1:0] s_axis_tuser;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [UW-1:0] m_axis_tuser;
   logic [LW-1:0] min_len;
   logic [LW-1:0] max_len;
   logic [LW-1:0] status_frame_len;
   logic          status_frame_valid;
   logic          status_too_short;
   logic          status_too_long;

   always #5 clk = ~clk;

   axis_frame_len_check #(
      .DATA_WIDTH (DW),
      .KEEP_WIDTH (KW),
      .USER_WIDTH (UW),
      .LEN_WIDTH  (LW)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .s_axis_tdata       (s_axis_tdata),
      .s_axis_tkeep       (s_axis_tkeep),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tready      (s_axis_tready),
      .s_axis_tlast       (s_axis_tlast),
      .s_axis_tuser       (s_axis_tuser),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tkeep       (m_axis_tkeep),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tready      (m_axis_tready),
      .m_axis_tlast       (m_axis_tlast),
      .m_axis_tuser       (m_axis_tuser),
      .min_len            (min_len),
      .max_len            (max_len),
      .status_frame_len   (status_frame_len),
      .status_frame_valid (status_frame_valid),
      .status_too_short   (status_too_short),
      .status_too_long    (status_too_long)
   );

   typedef struct {
      int         nbeats;
      logic [3:0] last_keep;
      logic [7:0] min_l;
      logic [7:0] max_l;
      bit         bp;
      logic [7:0] e_len;
      bit         e_short;
      bit         e_long;
      int         e_out;
   } rec_t;

   rec_t        tbl[NREC];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          bp_mode = 0;
   logic [37:0] got_q[$];
   logic [37:0] exp_q[$];
   logic [9:0]  got_s[$];
   logic [9:0]  exp_s[$];
   int          got_sc[$];
   int          exp_sc[$];
   bit          prev_stall = 1'b0;
   logic [37:0] prev_beat;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 99) >= 30);
            default: m_axis_tready = 1'b0;
         endcase
      end
   end

   // output monitor: beats, status pulses, and stability while stalled
   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
                64'({1'b1, prev_beat}));
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_beat  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
         if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
         end
         if (status_frame_valid) begin
            got_s.push_back({status_frame_len, status_too_short, status_too_long});
            got_sc.push_back(cyc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      bit rdy;
      bit ok;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tuser  = 1'b0;
      s_axis_tvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         rdy = s_axis_tready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept", 64'(ok), 64'd1);
   endtask

   task automatic send_frame(input int f);
      rec_t        r;
      logic [31:0] d;
      logic [3:0]  k;
      logic        lst;
      logic        usr;
      bit          bad;
      r   = tbl[f];
      bad = r.e_short | r.e_long;
      for (int b = 0; b < r.nbeats; b++) begin
         d = {8'(f), 8'(b), 16'hBEEF};
         k = (b == r.nbeats - 1) ? r.last_keep : 4'hF;
         if (b == 0) begin
            min_len = r.min_l;
            max_len = r.max_l;
         end
         send_beat(d, k, (b == r.nbeats - 1));
         // limits must have been captured on the first beat
         if (b == 0) begin
            min_len = 8'hFF;
            max_len = 8'h01;
         end
         if (b < r.e_out) begin
            lst = (b == r.e_out - 1);
            usr = lst & bad;
            exp_q.push_back({d, k, lst, usr});
         end
         if (b == r.nbeats - 1) begin
            exp_s.push_back({r.e_len, r.e_short, r.e_long});
            exp_sc.push_back(cyc);
         end
      end
   endtask

   task automatic drain_compare();
      int n;
      s_axis_tvalid = 1'b0;
      bp_mode = 0;
      for (int t = 0; t < 3000; t++) begin
         if (got_q.size() >= exp_q.size() && got_s.size() >= exp_s.size()) break;
         @(posedge clk);
      end
      repeat (4) @(posedge clk);
      #1;
      chk("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("beat[%0d]", i), 64'(got_q[i]), 64'(exp_q[i]));
      end
      chk("status_count", 64'(got_s.size()), 64'(exp_s.size()));
      n = (got_s.size() < exp_s.size()) ? got_s.size() : exp_s.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("status[%0d]", i), 64'(got_s[i]), 64'(exp_s[i]));
         chk($sformatf("status_cycle[%0d]", i), 64'(got_sc[i]), 64'(exp_sc[i]));
      end
      got_q.delete();
      exp_q.delete();
      got_s.delete();
      exp_s.delete();
      got_sc.delete();
      exp_sc.delete();
   endtask

   initial begin
      rst           = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = '0;
      min_len       = '0;
      max_len       = '0;

      //             beats last   min    max    bp    len     short long  out
      tbl[0]  = '{4,  4'hF, 8'd8, 8'd64,  1'b0, 8'd16,  1'b0, 1'b0, 4};
      tbl[1]  = '{1,  4'h3, 8'd8, 8'd64,  1'b0, 8'd2,   1'b1, 1'b0, 1};
      tbl[2]  = '{17, 4'hF, 8'd8, 8'd64,  1'b0, 8'd68,  1'b0, 1'b1, 17};
      tbl[3]  = '{20, 4'hF, 8'd8, 8'd64,  1'b0, 8'd80,  1'b0, 1'b1, TRUNC ? 17 : 20};
      tbl[4]  = '{16, 4'hF, 8'd8, 8'd64,  1'b0, 8'd64,  1'b0, 1'b0, 16};
      tbl[5]  = '{2,  4'hF, 8'd8, 8'd64,  1'b0, 8'd8,   1'b0, 1'b0, 2};
      tbl[6]  = '{2,  4'h7, 8'd8, 8'd64,  1'b0, 8'd7,   1'b1, 1'b0, 2};
      tbl[7]  = '{20, 4'hF, 8'd8, 8'd0,   1'b0, 8'd80,  1'b0, 1'b0, 20};
      tbl[8]  = '{70, 4'hF, 8'd0, 8'd0,   1'b0, 8'd255, 1'b0, 1'b0, 70};
      tbl[9]  = '{70, 4'hF, 8'd0, 8'd200, 1'b0, 8'd255, 1'b0, 1'b1, TRUNC ? 51 : 70};
      tbl[10] = '{3,  4'h1, 8'd0, 8'd9,   1'b0, 8'd9,   1'b0, 1'b0, 3};
      tbl[11] = '{3,  4'h3, 8'd0, 8'd9,   1'b0, 8'd10,  1'b0, 1'b1, 3};
      tbl[12] = '{5,  4'hF, 8'd8, 8'd64,  1'b1, 8'd20,  1'b0, 1'b0, 5};
      tbl[13] = '{1,  4'h1, 8'd8, 8'd64,  1'b1, 8'd1,   1'b1, 1'b0, 1};
      tbl[14] = '{6,  4'hC, 8'd8, 8'd64,  1'b1, 8'd22,  1'b0, 1'b0, 6};
      tbl[15] = '{18, 4'hF, 8'd8, 8'd64,  1'b1, 8'd72,  1'b0, 1'b1, TRUNC ? 17 : 18};
      tbl[16] = '{1,  4'hF, 8'd4, 8'd4,   1'b1, 8'd4,   1'b0, 1'b0, 1};
      tbl[17] = '{3,  4'hA, 8'd0, 8'd64,  1'b1, 8'd10,  1'b0, 1'b0, 3};
      tbl[18] = '{2,  4'hF, 8'd8, 8'd64,  1'b0, 8'd8,   1'b0, 1'b0, 2};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_status", 64'({status_frame_valid, status_frame_len, status_too_short, status_too_long}), 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_s_tready", 64'(s_axis_tready), 64'd1);

      for (int i = 0; i < NREC - 1; i++) begin
         bp_mode = tbl[i].bp ? 1 : 0;
         send_frame(i);
         if (i == NREC - 2) begin
            drain_compare();
         end else if (!tbl[i + 1].bp) begin
            drain_compare();
         end
      end

      // fill the slice against a stalled sink, then reset with beats in flight
      bp_mode = 2;
      @(posedge clk);
      #2;
      send_beat(32'hA0A0_A0A0, 4'hF, 1'b0);
      chk("latency_m_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("latency_m_tdata", 64'(m_axis_tdata), 64'hA0A0_A0A0);
      chk("one_held_s_tready", 64'(s_axis_tready), 64'd1);
      send_beat(32'hB1B1_B1B1, 4'hF, 1'b0);
      chk("two_held_s_tready", 64'(s_axis_tready), 64'd0);
      chk("stall_m_tdata", 64'(m_axis_tdata), 64'hA0A0_A0A0);
      s_axis_tdata = 32'hC2C2_C2C2;
      rst = 1'b1;
      #1;
      chk("rst_mid_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_mid_s_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_mid_status", 64'({status_frame_valid, status_frame_len, status_too_short, status_too_long}), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      s_axis_tvalid = 1'b0;
      bp_mode = 0;
      #1;
      chk("rst_exit_s_tready", 64'(s_axis_tready), 64'd1);
      chk("rst_discard_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      @(posedge clk);
      #1;
      send_frame(NREC - 1);
      drain_compare();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
